// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - active-low push-button synchronizer and debouncer
// Produces a clean level plus single-cycle press, release and long-press pulses.
module key_debounce #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DEBOUNCE_CYC = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYC     = CLK_FREQ_HZ / 1000 * LONG_MS;
  localparam int DEB_W        = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W       = $clog2(LONG_CYC + 1);

  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYC);
  localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);
  localparam bit                DEB_SINGLE = (DEBOUNCE_CYC == 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic              sync1_q, sync2_q;
  logic              key_sync;
  state_t            state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d, deb_inc;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
  logic              hold_hit;
  logic              key_state_q, key_state_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  assign key_sync = sync2_q;

  // Saturating increments; hold_hit fires only on the transition into LONG_CYC.
  assign deb_inc  = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + 1'b1;
  assign hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
  assign hold_hit = (hold_cnt_q != HOLD_MAX) && (hold_inc == HOLD_MAX);

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    key_state_d = key_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (!key_sync) begin
          if (DEB_SINGLE) begin
            state_d     = PRESSED;
            key_state_d = 1'b0;
            press_d     = 1'b1;
            deb_cnt_d   = '0;
          end else begin
            state_d   = PRESS_WAIT;
            deb_cnt_d = DEB_ONE;
          end
        end
      end

      PRESS_WAIT: begin
        if (key_sync) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_inc == DEB_MAX) begin
          state_d     = PRESSED;
          key_state_d = 1'b0;
          press_d     = 1'b1;
          hold_cnt_d  = '0;
          deb_cnt_d   = '0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end

      PRESSED: begin
        hold_cnt_d = hold_inc;
        long_d     = hold_hit;
        if (key_sync) begin
          if (DEB_SINGLE) begin
            state_d     = IDLE;
            key_state_d = 1'b1;
            release_d   = 1'b1;
            long_d      = 1'b0;
            hold_cnt_d  = '0;
            deb_cnt_d   = '0;
          end else begin
            state_d   = RELEASE_WAIT;
            deb_cnt_d = DEB_ONE;
          end
        end
      end

      RELEASE_WAIT: begin
        hold_cnt_d = hold_inc;
        long_d     = hold_hit;
        if (!key_sync) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (deb_inc == DEB_MAX) begin
          // Release takes priority over a coincident long-press pulse.
          state_d     = IDLE;
          key_state_d = 1'b1;
          release_d   = 1'b1;
          long_d      = 1'b0;
          hold_cnt_d  = '0;
          deb_cnt_d   = '0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end

      default: begin
        state_d     = IDLE;
        deb_cnt_d   = '0;
        hold_cnt_d  = '0;
        key_state_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      key_state_q <= 1'b1;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q     <= key;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed and randomized bench for key_debounce
// Reference model: debounced level flips once the last DEB synchronized samples all disagree with it.
module tb_key_debounce;

  localparam int DEB  = 5;
  localparam int LONG = 20;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic key;
  logic key_state, key_press, key_release, key_long;

  int checks = 0;
  int errors = 0;

  bit pin_h[$];
  bit sync_h[$];
  bit m_state, m_press, m_rel, m_long;
  int edge_n = 0;
  int press_edge;

  int n_press = 0, n_rel = 0, n_long = 0;
  int last_press_edge = -1, last_long_edge = -1;
  int t0, p0, r0, l0, lat;

  key_debounce #(
    .CLK_FREQ_HZ(1000),
    .DEBOUNCE_MS(5),
    .LONG_MS    (20)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key        (key),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic model_reset();
    pin_h.delete();
    sync_h.delete();
    pin_h.push_back(1'b1);
    pin_h.push_back(1'b1);
    m_state    = 1'b1;
    m_press    = 1'b0;
    m_rel      = 1'b0;
    m_long     = 1'b0;
    press_edge = -1000;
  endtask

  task automatic model_edge(input bit k);
    bit u;
    bit all_diff;
    edge_n++;
    pin_h.push_back(k);
    u = pin_h[pin_h.size() - 3];
    if (pin_h.size() > 8) pin_h.pop_front();
    sync_h.push_back(u);
    if (sync_h.size() > 16) sync_h.pop_front();
    m_press  = 1'b0;
    m_rel    = 1'b0;
    m_long   = 1'b0;
    all_diff = (sync_h.size() >= DEB);
    if (all_diff)
      for (int i = 0; i < DEB; i++)
        if (sync_h[sync_h.size() - 1 - i] == m_state) all_diff = 1'b0;
    if (all_diff) begin
      if (m_state) begin
        m_press    = 1'b1;
        press_edge = edge_n;
      end else begin
        m_rel = 1'b1;
      end
      m_state = ~m_state;
    end
    if (!m_state && !m_rel && (edge_n - press_edge == LONG)) m_long = 1'b1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0b expected=%0b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit k);
    key = k;
    @(posedge sys_clk);
    model_edge(k);
    @(negedge sys_clk);
    check_bit("key_state", key_state, m_state);
    check_bit("key_press", key_press, m_press);
    check_bit("key_release", key_release, m_rel);
    check_bit("key_long", key_long, m_long);
    if (key_press)   begin n_press++; last_press_edge = edge_n; end
    if (key_release) n_rel++;
    if (key_long)    begin n_long++; last_long_edge = edge_n; end
  endtask

  // Hold the key low until a press pulse appears (bounded); returns pin-edge-to-pulse latency.
  task automatic press_and_measure(output int latency);
    int base_edge;
    int base_cnt;
    base_edge = edge_n;
    base_cnt  = n_press;
    for (int i = 0; i < 20 && n_press == base_cnt; i++) step(1'b0);
    latency = (n_press == base_cnt) ? -1 : last_press_edge - base_edge;
  endtask

  initial begin
    sys_rst = 1'b1;
    key     = 1'b1;
    model_reset();
    repeat (3) @(negedge sys_clk);
    check_bit("reset_key_state", key_state, 1'b1);
    check_bit("reset_pulses", key_press | key_release | key_long, 1'b0);
    sys_rst = 1'b0;

    // Idle released for 50 cycles
    repeat (50) step(1'b1);
    check_int("idle_press_count", n_press, 0);
    check_int("idle_release_count", n_rel, 0);

    // Clean press: pulse 2+DEB cycles after the pin edge, then a 40-cycle hold
    press_and_measure(lat);
    check_int("clean_press_latency", lat, 2 + DEB);
    check_int("clean_press_count", n_press, 1);
    repeat (40) step(1'b0);
    check_int("long_count_single", n_long, 1);
    check_int("long_after_press", last_long_edge - last_press_edge, LONG);
    r0 = n_rel;
    repeat (15) step(1'b1);
    check_int("release_after_long", n_rel - r0, 1);

    // Bouncy press: low 3, high 2, low 3, then steady low
    p0 = n_press;
    repeat (3) step(1'b0);
    repeat (2) step(1'b1);
    check_int("bounce_no_press", n_press, p0);
    press_and_measure(lat);
    check_int("bounce_press_latency", lat, 2 + DEB);
    check_int("bounce_press_count", n_press - p0, 1);
    repeat (10) step(1'b1);

    // Short hold with a 2-cycle release bounce: one release, no long
    l0 = n_long;
    r0 = n_rel;
    press_and_measure(lat);
    repeat (3) step(1'b0);
    repeat (2) step(1'b1);
    repeat (2) step(1'b0);
    repeat (15) step(1'b1);
    check_int("bounce_release_count", n_rel - r0, 1);
    check_int("short_hold_no_long", n_long, l0);

    // Release debounce completes exactly when hold reaches LONG: release wins
    l0 = n_long;
    r0 = n_rel;
    press_and_measure(lat);
    repeat (13) step(1'b0);
    repeat (15) step(1'b1);
    check_int("coincident_release", n_rel - r0, 1);
    check_int("coincident_long_dropped", n_long, l0);

    // One cycle later: long fires while release is still being debounced
    l0 = n_long;
    press_and_measure(lat);
    repeat (14) step(1'b0);
    repeat (15) step(1'b1);
    check_int("long_in_release_wait", n_long - l0, 1);

    // Async reset while pressed, then a fresh press after release
    press_and_measure(lat);
    repeat (3) step(1'b0);
    #2 sys_rst = 1'b1;
    #1;
    check_bit("async_reset_state", key_state, 1'b1);
    check_bit("async_reset_pulses", key_press | key_release | key_long, 1'b0);
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    press_and_measure(lat);
    check_int("post_reset_press_latency", lat, 2 + DEB);
    repeat (10) step(1'b1);

    // Randomized bursts of bounce and holds
    for (int b = 0; b < 60; b++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(18, 30)) : int'($urandom_range(1, 8));
      repeat (len) step(lvl);
    end
    repeat (30) step(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
